store_buffer_drain_ctrl: RTL and testbench
==========================================

Name: store_buffer_drain_ctrl

Overview:
- Sequences the retire store buffer drain and shares the single data-memory port between committed-store writeback and load misses from the LSQ.
- Pops the buffer head only after memory accepts the write.
- Prioritises loads unless buffer occupancy, starvation or an explicit flush forces stores.
- Sits between the retire store buffer, the load miss path and the D-memory interface.

Parameters:
- SB_DEPTH, 8, retire store buffer entries; CW = $clog2(SB_DEPTH)+1.
- HIGH_WM, 6, occupancy at or above which stores take priority over loads.
- STARVE_MAX, 4, consecutive load grants with a non-empty buffer before a store is forced.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sb_empty  in  1  store buffer empty.
- sb_count  in  CW  store buffer occupancy.
- sb_head  in  SQ_ENTRY_PACKET  buffer head entry (addr, value, mem_size).
- sb_rd_en  out  1  pop the head; one-cycle pulse.
- ld_req  in  1  load miss request.
- ld_addr  in  32  load address.
- ld_size  in  3  load mem_size.
- ld_gnt  out  1  load accepted; pulse.
- ld_done  out  1  load data valid; pulse.
- ld_data  out  32  returned load data.
- flush_i  in  1  drain-all request; pulse.
- drain_done  out  1  flush complete; pulse.
- mem_cmd  out  2  0 = NONE, 1 = LOAD, 2 = STORE.
- mem_addr  out  32  memory address.
- mem_data  out  32  store data.
- mem_size  out  3  access size.
- mem_ack  in  1  memory accepts the command this cycle.
- mem_rd_valid  in  1  load data returned.
- mem_rd_data  in  32  load data.

Behaviour:
- Reset values: state IDLE, starve_cnt 0, flush_active 0, all outputs 0, mem_cmd NONE.
- Reset mid-transaction abandons the transaction: no pop, no ld_done.
- FSM states: IDLE, ST_ISSUE, LD_ISSUE, LD_WAIT. At most one transaction is outstanding.
- IDLE arbitration, decided each cycle:
  - force = flush_active | (sb_count >= HIGH_WM) | (starve_cnt >= STARVE_MAX).
  - If force and !sb_empty: go to ST_ISSUE.
  - Else if ld_req and !flush_active: pulse ld_gnt, latch ld_addr/ld_size, go to LD_ISSUE.
  - Else if !sb_empty: go to ST_ISSUE.
  - Else stay in IDLE.
- ST_ISSUE:
  - mem_cmd = STORE; addr/data/size driven combinationally from sb_head and held until mem_ack.
  - On mem_ack: sb_rd_en = 1 in the same cycle, starve_cnt cleared, go to IDLE.
  - Throughput is therefore at most one store per 2 cycles.
- LD_ISSUE:
  - mem_cmd = LOAD with the latched addr/size; mem_data = 0.
  - On mem_ack: go to LD_WAIT.
  - If the buffer was non-empty at grant, starve_cnt increments at grant, saturating at STARVE_MAX.
- LD_WAIT:
  - mem_cmd = NONE.
  - On mem_rd_valid: ld_done = 1, ld_data = mem_rd_data (registered output, visible the next cycle together with ld_done), go to IDLE.
  - mem_rd_valid outside LD_WAIT is ignored.
- mem_cmd is NONE in IDLE; a command is visible the cycle after the IDLE decision.
- Flush:
  - flush_i sets flush_active; a flush_i while already active is absorbed.
  - drain_done pulses for one cycle when flush_active, state == IDLE and sb_empty; flush_active clears in the same cycle.
  - A flush_i arriving while a load is in flight completes that load first and blocks new loads.
  - A flush on an empty, idle controller yields drain_done the cycle after flush_i.
- sb_empty with sb_count >= HIGH_WM is inconsistent input: treat as empty, no store issued.
- starve_cnt width is $clog2(STARVE_MAX+1); it never wraps.

Test Plan:
- Single store, sb_count = 1, head addr 0x100, value 0xDEAD, mem_ack two cycles after issue → mem_cmd = 2 for exactly 2 cycles, sb_rd_en pulses in the ack cycle, then mem_cmd = 0.
- Load only, addr 0x200, ack immediately, mem_rd_valid 3 cycles later with 0x1234 → ld_gnt 1 pulse, mem_cmd = 1 for 1 cycle, ld_done pulse with ld_data = 0x1234.
- Starvation: sb_count = 2 and ld_req held high, each load acked and returned in 1 cycle → 4 loads granted, then a store is issued and popped, then loads resume.
- Watermark: sb_count = 6 and ld_req high simultaneously → store wins in IDLE; ld_gnt stays 0 until sb_count drops to 5.
- Flush: 3 entries buffered, flush_i pulse while a load sits in LD_WAIT → load completes; 3 store pops with ld_req ignored; drain_done pulses once after the buffer empties.
- Reset asserted in ST_ISSUE before mem_ack → no sb_rd_en; all outputs 0 the next cycle; state IDLE.

Source files
------------

// File: rtl/store_buffer_drain_ctrl_if.sv
// Shared types and the data-memory port bundle for the store buffer drain controller.
package store_buffer_drain_ctrl_pkg;

  // Entry at the head of the retire store buffer.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] value;
    logic [2:0]  mem_size;
  } sq_entry_packet_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_e;

endpackage

interface store_buffer_drain_ctrl_if;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  mem_size;
  logic        mem_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  modport master (
    output mem_cmd, mem_addr, mem_data, mem_size,
    input  mem_ack, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_cmd, mem_addr, mem_data, mem_size,
    output mem_ack, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/store_buffer_drain_ctrl.sv
// Arbitrates the single D-memory port between store buffer drain and load misses.
module store_buffer_drain_ctrl
  import store_buffer_drain_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH   = 8,
  parameter int unsigned HIGH_WM    = 6,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CW        = $clog2(SB_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sb_empty,
  input  logic [CW-1:0]       sb_count,
  input  sq_entry_packet_t    sb_head,
  output logic                sb_rd_en,
  input  logic                ld_req,
  input  logic [31:0]         ld_addr,
  input  logic [2:0]          ld_size,
  output logic                ld_gnt,
  output logic                ld_done,
  output logic [31:0]         ld_data,
  input  logic                flush_i,
  output logic                drain_done,
  store_buffer_drain_ctrl_if.master mem
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ST_ISSUE, LD_ISSUE, LD_WAIT} state_e;

  state_e          state, state_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic            flush_active, flush_nxt;
  logic [31:0]     ld_addr_q;
  logic [2:0]      ld_size_q;
  logic            ld_latch;
  logic            force_st;

  // State, counters, load latch and registered load-return outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      flush_active <= 1'b0;
      ld_addr_q    <= '0;
      ld_size_q    <= '0;
      ld_done      <= 1'b0;
      ld_data      <= '0;
    end else begin
      state        <= state_nxt;
      starve_cnt   <= starve_nxt;
      flush_active <= flush_nxt;
      if (ld_latch) begin
        ld_addr_q <= ld_addr;
        ld_size_q <= ld_size;
      end
      ld_done <= (state == LD_WAIT) && mem.mem_rd_valid;
      if ((state == LD_WAIT) && mem.mem_rd_valid) begin
        ld_data <= mem.mem_rd_data;
      end
    end
  end

  // Next-state arbitration and memory command decode; everything gated off during reset.
  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    flush_nxt    = flush_active | flush_i;
    sb_rd_en     = 1'b0;
    ld_gnt       = 1'b0;
    drain_done   = 1'b0;
    ld_latch     = 1'b0;
    mem.mem_cmd  = MEM_NONE;
    mem.mem_addr = '0;
    mem.mem_data = '0;
    mem.mem_size = '0;
    force_st     = flush_active | (sb_count >= CW'(HIGH_WM)) |
                   (starve_cnt >= SW'(STARVE_MAX));

    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (force_st && !sb_empty) begin
            state_nxt = ST_ISSUE;
          end else if (ld_req && !flush_active) begin
            ld_gnt    = 1'b1;
            ld_latch  = 1'b1;
            state_nxt = LD_ISSUE;
            if (!sb_empty && (starve_cnt < SW'(STARVE_MAX))) begin
              starve_nxt = starve_cnt + SW'(1);
            end
          end else if (!sb_empty) begin
            state_nxt = ST_ISSUE;
          end
          if (flush_active && sb_empty) begin
            drain_done = 1'b1;
            flush_nxt  = flush_i;
          end
        end
        ST_ISSUE: begin
          mem.mem_cmd  = MEM_STORE;
          mem.mem_addr = sb_head.addr;
          mem.mem_data = sb_head.value;
          mem.mem_size = sb_head.mem_size;
          if (mem.mem_ack) begin
            sb_rd_en   = 1'b1;
            starve_nxt = '0;
            state_nxt  = IDLE;
          end
        end
        LD_ISSUE: begin
          mem.mem_cmd  = MEM_LOAD;
          mem.mem_addr = ld_addr_q;
          mem.mem_size = ld_size_q;
          if (mem.mem_ack) begin
            state_nxt = LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (mem.mem_rd_valid) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_drain_ctrl.sv
// Directed self-checking bench for store_buffer_drain_ctrl.
module tb_store_buffer_drain_ctrl;
  import store_buffer_drain_ctrl_pkg::*;

  localparam int unsigned CW = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             sb_empty;
  logic [CW-1:0]    sb_count;
  sq_entry_packet_t sb_head;
  logic             sb_rd_en;
  logic             ld_req;
  logic [31:0]      ld_addr;
  logic [2:0]       ld_size;
  logic             ld_gnt;
  logic             ld_done;
  logic [31:0]      ld_data;
  logic             flush_i;
  logic             drain_done;

  int checks = 0;
  int errors = 0;

  store_buffer_drain_ctrl_if mem_if ();

  store_buffer_drain_ctrl #(.SB_DEPTH(8), .HIGH_WM(6), .STARVE_MAX(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count),
    .sb_head    (sb_head),
    .sb_rd_en   (sb_rd_en),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_size    (ld_size),
    .ld_gnt     (ld_gnt),
    .ld_done    (ld_done),
    .ld_data    (ld_data),
    .flush_i    (flush_i),
    .drain_done (drain_done),
    .mem        (mem_if.master)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb_empty = 1'b1; sb_count = '0; sb_head = '0;
    ld_req = 1'b0; ld_addr = '0; ld_size = '0; flush_i = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rd_valid = 1'b0; mem_if.mem_rd_data = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_if.mem_cmd, sb_rd_en, ld_gnt, ld_done, drain_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got cmd=%0d rd=%b gnt=%b done=%b drain=%b, expected all 0",
               mem_if.mem_cmd, sb_rd_en, ld_gnt, ld_done, drain_done);
    end
    checks++;
    if (ld_data !== 32'h0 || mem_if.mem_addr !== 32'h0 || mem_if.mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got ld_data=%h addr=%h data=%h, expected 0",
               ld_data, mem_if.mem_addr, mem_if.mem_data);
    end
  endtask

  task automatic test_single_store();
    apply_reset();
    sb_empty = 1'b0; sb_count = 4'd1;
    sb_head = '{addr: 32'h100, value: 32'hDEAD, mem_size: 3'd2};
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd0) begin
      errors++; $display("FAIL store_idle_cmd: got %0d expected 0", mem_if.mem_cmd);
    end
    step();
    checks++;
    if (mem_if.mem_cmd !== 2'd2 || mem_if.mem_addr !== 32'h100 || mem_if.mem_data !== 32'hDEAD ||
        mem_if.mem_size !== 3'd2 || sb_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL store_issue1: got cmd=%0d addr=%h data=%h size=%0d rd=%b, expected 2 100 dead 2 0",
               mem_if.mem_cmd, mem_if.mem_addr, mem_if.mem_data, mem_if.mem_size, sb_rd_en);
    end
    step();
    mem_if.mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd2 || sb_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL store_ack: got cmd=%0d rd=%b, expected 2 1", mem_if.mem_cmd, sb_rd_en);
    end
    step();
    mem_if.mem_ack = 1'b0; sb_empty = 1'b1; sb_count = '0;
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd0 || sb_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL store_after: got cmd=%0d rd=%b, expected 0 0", mem_if.mem_cmd, sb_rd_en);
    end
  endtask

  task automatic test_load();
    apply_reset();
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = 3'd2;
    #1;
    checks++;
    if (ld_gnt !== 1'b1 || mem_if.mem_cmd !== 2'd0) begin
      errors++; $display("FAIL load_gnt: got gnt=%b cmd=%0d, expected 1 0", ld_gnt, mem_if.mem_cmd);
    end
    step();
    ld_req = 1'b0; ld_addr = 32'hFFFF; mem_if.mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd1 || mem_if.mem_addr !== 32'h200 || mem_if.mem_size !== 3'd2 ||
        mem_if.mem_data !== 32'h0 || ld_gnt !== 1'b0) begin
      errors++;
      $display("FAIL load_issue: got cmd=%0d addr=%h size=%0d data=%h gnt=%b, expected 1 200 2 0 0",
               mem_if.mem_cmd, mem_if.mem_addr, mem_if.mem_size, mem_if.mem_data, ld_gnt);
    end
    step();
    mem_if.mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_if.mem_cmd !== 2'd0 || ld_done !== 1'b0) begin
        errors++;
        $display("FAIL load_wait%0d: got cmd=%0d done=%b, expected 0 0", i, mem_if.mem_cmd, ld_done);
      end
      step();
    end
    mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h1234;
    step();
    mem_if.mem_rd_valid = 1'b0;
    checks++;
    if (ld_done !== 1'b1 || ld_data !== 32'h1234) begin
      errors++; $display("FAIL load_done: got done=%b data=%h, expected 1 1234", ld_done, ld_data);
    end
    mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'h5555;
    step();
    mem_if.mem_rd_valid = 1'b0;
    checks++;
    if (ld_done !== 1'b0 || ld_data !== 32'h1234) begin
      errors++;
      $display("FAIL load_stray_valid: got done=%b data=%h, expected 0 1234", ld_done, ld_data);
    end
  endtask

  task automatic test_starvation();
    logic [14:0] gv, rv, dv;
    apply_reset();
    sb_empty = 1'b0; sb_count = 4'd2;
    sb_head = '{addr: 32'h400, value: 32'h55, mem_size: 3'd2};
    ld_req = 1'b1; ld_addr = 32'h300; ld_size = 3'd2;
    mem_if.mem_ack = 1'b1; mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hA5;
    #1;
    for (int i = 0; i < 15; i++) begin
      gv[i] = ld_gnt; rv[i] = sb_rd_en; dv[i] = ld_done;
      step();
      if (rv[i]) sb_count = sb_count - 4'd1;
      #1;
    end
    checks++;
    if (gv !== 15'h4249) begin
      errors++; $display("FAIL starve_gnt: got %h expected 4249", gv);
    end
    checks++;
    if (rv !== 15'h2000) begin
      errors++; $display("FAIL starve_pop: got %h expected 2000", rv);
    end
    checks++;
    if (dv !== 15'h1248) begin
      errors++; $display("FAIL starve_done: got %h expected 1248", dv);
    end
  endtask

  task automatic test_watermark();
    apply_reset();
    sb_empty = 1'b0; sb_count = 4'd6;
    sb_head = '{addr: 32'h500, value: 32'h77, mem_size: 3'd1};
    ld_req = 1'b1; ld_addr = 32'h600;
    #1;
    checks++;
    if (ld_gnt !== 1'b0) begin
      errors++; $display("FAIL wm_idle_gnt: got %b expected 0", ld_gnt);
    end
    step();
    mem_if.mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd2 || sb_rd_en !== 1'b1 || ld_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wm_store: got cmd=%0d rd=%b gnt=%b, expected 2 1 0", mem_if.mem_cmd, sb_rd_en, ld_gnt);
    end
    step();
    mem_if.mem_ack = 1'b0; sb_count = 4'd5;
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL wm_below_gnt: got %b expected 1", ld_gnt);
    end
  endtask

  task automatic test_flush();
    logic [7:0] gv, rv, drv;
    apply_reset();
    sb_empty = 1'b0; sb_count = 4'd3;
    sb_head = '{addr: 32'h700, value: 32'h99, mem_size: 3'd2};
    ld_req = 1'b1; ld_addr = 32'h800; ld_size = 3'd2;
    #1;
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_first_gnt: got %b expected 1", ld_gnt);
    end
    step();
    ld_req = 1'b0; mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; ld_req = 1'b1;
    mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hBEEF;
    step();
    mem_if.mem_rd_valid = 1'b0; mem_if.mem_ack = 1'b1;
    #1;
    checks++;
    if (ld_done !== 1'b1 || ld_data !== 32'hBEEF) begin
      errors++; $display("FAIL flush_load_done: got done=%b data=%h, expected 1 beef", ld_done, ld_data);
    end
    for (int i = 0; i < 8; i++) begin
      gv[i] = ld_gnt; rv[i] = sb_rd_en; drv[i] = drain_done;
      step();
      if (rv[i]) begin
        sb_count = sb_count - 4'd1;
        if (sb_count == 4'd0) sb_empty = 1'b1;
      end
      #1;
    end
    mem_if.mem_ack = 1'b0; ld_req = 1'b0;
    checks++;
    if (rv !== 8'h2A) begin
      errors++; $display("FAIL flush_pops: got %h expected 2a", rv);
    end
    checks++;
    if (drv !== 8'h40) begin
      errors++; $display("FAIL flush_drain_done: got %h expected 40", drv);
    end
    checks++;
    if (gv !== 8'h80) begin
      errors++; $display("FAIL flush_gnt: got %h expected 80", gv);
    end
  endtask

  task automatic test_flush_empty();
    apply_reset();
    flush_i = 1'b1;
    #1;
    checks++;
    if (drain_done !== 1'b0) begin
      errors++; $display("FAIL flush_empty_same: got %b expected 0", drain_done);
    end
    step();
    flush_i = 1'b0;
    #1;
    checks++;
    if (drain_done !== 1'b1) begin
      errors++; $display("FAIL flush_empty_next: got %b expected 1", drain_done);
    end
    step();
    checks++;
    if (drain_done !== 1'b0) begin
      errors++; $display("FAIL flush_empty_once: got %b expected 0", drain_done);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sb_empty = 1'b0; sb_count = 4'd1;
    sb_head = '{addr: 32'h900, value: 32'h11, mem_size: 3'd2};
    step();
    checks++;
    if (mem_if.mem_cmd !== 2'd2) begin
      errors++; $display("FAIL rst_mid_issue: got %0d expected 2", mem_if.mem_cmd);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_cmd !== 2'd0 || sb_rd_en !== 1'b0 || ld_done !== 1'b0 || ld_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got cmd=%0d rd=%b done=%b gnt=%b, expected 0 0 0 0",
               mem_if.mem_cmd, sb_rd_en, ld_done, ld_gnt);
    end
    step();
    checks++;
    if (mem_if.mem_cmd !== 2'd2) begin
      errors++; $display("FAIL rst_mid_restart: got %0d expected 2", mem_if.mem_cmd);
    end
    // Load abandoned by reset while its data returns.
    apply_reset();
    ld_req = 1'b1; ld_addr = 32'hA00;
    step();
    ld_req = 1'b0; mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0; mem_if.mem_rd_valid = 1'b1; mem_if.mem_rd_data = 32'hCAFE;
    reset = 1'b1;
    step();
    reset = 1'b0; mem_if.mem_rd_valid = 1'b0;
    #1;
    checks++;
    if (ld_done !== 1'b0 || ld_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_load: got done=%b data=%h, expected 0 0", ld_done, ld_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_load();
    test_starvation();
    test_watermark();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
